// File: rtl/uart_imem_loader.sv
// UART-to-instruction-memory boot loader: packs bytes little-endian into words, stops on END_WORDS all-ones words.
// Optional byte timeout enabled by defining LOADER_TIMEOUT_EN; default build holds partial words indefinitely.
module uart_imem_loader #(
  parameter int WORD_BYTES     = 4,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter int END_WORDS      = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_en,
  input  logic                    uart_rx_valid,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_rx_break,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [ADDR_W:0]         word_count,
  output logic                    write_done,
  output logic                    overflow,
  output logic                    timeout_pulse
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCW-1:0]    LAST_BYTE = BCW'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]        END_W     = 3'(END_WORDS);

  if (WORD_BYTES < 1 || WORD_BYTES > 8 || END_WORDS < 1 || END_WORDS > 4 ||
      DEPTH < 1 || DEPTH > (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_imem_loader: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state;
  logic           valid_q;
  logic           valid_qq;
  logic           break_q;
  logic [7:0]     data_q;
  logic [BCW-1:0] byte_cnt;
  logic [W-1:0]   asm_word;
  logic [W-1:0]   asm_next;
  logic [2:0]     sent_cnt;
  logic [2:0]     sent_next;
  logic           rise;
  logic           accept;
  logic           last_byte;
  logic           tmo_fire;

  // All UART inputs pass through one register stage together, so a break
  // raised alongside a new byte is seen in the same cycle as its edge.
  assign rise      = valid_q & ~valid_qq;
  assign accept    = rise & ~break_q & load_en &
                     ((state == S_ASSEMBLE) || (state == S_WRITE));
  assign last_byte = (byte_cnt == LAST_BYTE);

  always_comb begin
    asm_next = asm_word;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byte_cnt == BCW'(k)) begin
        asm_next[8*k +: 8] = data_q;
      end
    end
  end

  always_comb begin
    sent_next = (&mem_wdata) ? (sent_cnt + 3'd1) : 3'd0;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;

  assign tmo_fire = load_en && (state == S_ASSEMBLE) && (byte_cnt != '0) &&
                    !accept && !break_q && (idle_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tmo_fire;
      if (!load_en || (state != S_ASSEMBLE) || (byte_cnt == '0) ||
          accept || break_q || tmo_fire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_fire      = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      valid_q    <= 1'b0;
      valid_qq   <= 1'b0;
      break_q    <= 1'b0;
      data_q     <= 8'h00;
      byte_cnt   <= '0;
      asm_word   <= '0;
      sent_cnt   <= 3'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      write_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid_q  <= uart_rx_valid;
      valid_qq <= valid_q;
      break_q  <= uart_rx_break;
      data_q   <= uart_rx_data;
      mem_we   <= 1'b0;

      if (!load_en) begin
        state      <= S_IDLE;
        byte_cnt   <= '0;
        sent_cnt   <= 3'd0;
        mem_addr   <= '0;
        word_count <= '0;
        write_done <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_ASSEMBLE;
          end

          S_ASSEMBLE: begin
            if (break_q) begin
              byte_cnt <= '0;
            end else if (accept) begin
              asm_word <= asm_next;
              if (last_byte) begin
                byte_cnt  <= '0;
                mem_wdata <= asm_next;
                mem_we    <= 1'b1;
                state     <= S_WRITE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else if (tmo_fire) begin
              byte_cnt <= '0;
            end
          end

          S_WRITE: begin
            mem_addr <= mem_addr + 1'b1;
            if (word_count < DEPTH_W) begin
              word_count <= word_count + 1'b1;
            end
            sent_cnt <= sent_next;
            if (sent_next == END_W) begin
              state      <= S_DONE;
              write_done <= 1'b1;
            end else if (mem_addr == LAST_ADDR) begin
              state    <= S_ERR;
              overflow <= 1'b1;
            end else if (accept) begin
              // byte_cnt is zero here, so this byte opens the next word
              asm_word <= asm_next;
              if (last_byte) begin
                mem_wdata <= asm_next;
                mem_we    <= 1'b1;
                state     <= S_WRITE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                state    <= S_ASSEMBLE;
              end
            end else begin
              state <= S_ASSEMBLE;
            end
          end

          default: begin
            // DONE and ERR hold until load_en drops or reset
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: a default-depth and a DEPTH=4 instance share stimulus, checked against a word-level model.
module tb_uart_imem_loader;

  localparam int ENDW = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load_en;
  logic       valid;
  logic [7:0] data;
  logic       brk;

  logic        a_mem_we, a_write_done, a_overflow, a_timeout_pulse;
  logic [4:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [5:0]  a_word_count;
  logic        b_mem_we, b_write_done, b_overflow, b_timeout_pulse;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_word_count;

  always #5 clk = ~clk;

  uart_imem_loader #(.WORD_BYTES(4), .ADDR_W(5), .DEPTH(32), .END_WORDS(2), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .resetn(resetn), .load_en(load_en), .uart_rx_valid(valid), .uart_rx_data(data),
    .uart_rx_break(brk), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .word_count(a_word_count), .write_done(a_write_done), .overflow(a_overflow),
    .timeout_pulse(a_timeout_pulse));

  uart_imem_loader #(.WORD_BYTES(4), .ADDR_W(2), .DEPTH(4), .END_WORDS(2), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .resetn(resetn), .load_en(load_en), .uart_rx_valid(valid), .uart_rx_data(data),
    .uart_rx_break(brk), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .word_count(b_word_count), .write_done(b_write_done), .overflow(b_overflow),
    .timeout_pulse(b_timeout_pulse));

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  int          ev[$];           // accepted bytes in order; -1 marks a discard (break/timeout)
  logic [31:0] exp_w[$];
  bit          exp_done, exp_ovf;

  always @(negedge clk) begin
    if (a_mem_we) begin qa_addr.push_back(32'(a_mem_addr)); qa_data.push_back(a_mem_wdata); end
    if (b_mem_we) begin qb_addr.push_back(32'(b_mem_addr)); qb_data.push_back(b_mem_wdata); end
    if (a_timeout_pulse) pulse_cnt++;
  end

  task automatic check(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    data = b; valid = 1'b1; ev.push_back(int'(b));
    tick(hold);
    valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], hold, gap);
  endtask

  task automatic send_break();
    brk = 1'b1; ev.push_back(-1);
    tick(1);
    brk = 1'b0;
    tick(1);
  endtask

  task automatic clear_logs();
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    ev.delete(); pulse_cnt = 0;
  endtask

  task automatic start_session();
    load_en = 1'b0;
    tick(2);
    clear_logs();
    load_en = 1'b1;
    tick(2);
  endtask

  // Word-level reference: group accepted bytes LSB-first, stop at the end marker or when memory is full.
  function automatic void model(input int depth);
    logic [31:0] part;
    int nb, run;
    exp_w.delete(); exp_done = 0; exp_ovf = 0; part = 0; nb = 0; run = 0;
    foreach (ev[i]) begin
      if (exp_done || exp_ovf) break;
      if (ev[i] < 0) begin
        nb = 0; part = 0;
      end else begin
        part[8*nb +: 8] = 8'(ev[i]);
        nb++;
        if (nb == 4) begin
          exp_w.push_back(part);
          run = (part == 32'hffffffff) ? run + 1 : 0;
          if (run == ENDW) exp_done = 1;
          else if (exp_w.size() == depth) exp_ovf = 1;
          nb = 0; part = 0;
        end
      end
    end
  endfunction

  task automatic check_dut(input bit sel);
    int n;
    string tg;
    tg = sel ? "b" : "a";
    model(sel ? 4 : 32);
    n = sel ? qb_data.size() : qa_data.size();
    check({tg, " nwrites"}, n, exp_w.size());
    for (int i = 0; i < n && i < exp_w.size(); i++) begin
      check({tg, " addr"}, sel ? qb_addr[i] : qa_addr[i], i);
      check({tg, " data"}, sel ? qb_data[i] : qa_data[i], exp_w[i]);
    end
    check({tg, " write_done"}, sel ? b_write_done : a_write_done, exp_done);
    check({tg, " overflow"}, sel ? b_overflow : a_overflow, exp_ovf);
    check({tg, " word_count"}, sel ? b_word_count : a_word_count, exp_w.size());
  endtask

  task automatic check_reset(input string tg);
    check({tg, " a outputs"}, {a_mem_we, a_mem_addr, a_mem_wdata, a_word_count,
                               a_write_done, a_overflow, a_timeout_pulse}, 0);
    check({tg, " b outputs"}, {b_mem_we, b_mem_addr, b_mem_wdata, b_word_count,
                               b_write_done, b_overflow, b_timeout_pulse}, 0);
  endtask

  typedef struct {
    logic [31:0] w [5];
    int          n;
    int          wr_a;
    bit          done_a;
    int          wr_b;
    bit          done_b;
    bit          ovf_b;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{'{32'hfe010113, 32'h00812e23, 32'hffffffff, 32'hffffffff, 32'h0}, 4, 4, 1, 4, 1, 0};
    tbl[1] = '{'{32'hffffffff, 32'h00000013, 32'hffffffff, 32'hffffffff, 32'h0}, 4, 4, 1, 4, 1, 0};
    tbl[2] = '{'{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005}, 5, 5, 0, 4, 0, 1};
    tbl[3] = '{'{32'hffffffff, 32'hffffffff, 32'h12345678, 32'h0, 32'h0}, 3, 2, 1, 2, 1, 0};
    tbl[4] = '{'{32'h11111111, 32'hffffffff, 32'h22222222, 32'h0, 32'h0}, 3, 3, 0, 3, 0, 0};

    resetn = 1'b0; load_en = 1'b0; valid = 1'b0; data = 8'h00; brk = 1'b0;
    tick(2);
    check_reset("reset");
    resetn = 1'b1;
    tick(1);

    // Table-driven programs, expectations fixed in the table.
    for (int t = 0; t < 5; t++) begin
      start_session();
      for (int i = 0; i < tbl[t].n; i++) send_word(tbl[t].w[i], 1, 1);
      tick(6);
      check($sformatf("tbl%0d a nwrites", t), qa_data.size(), tbl[t].wr_a);
      check($sformatf("tbl%0d a done", t), a_write_done, tbl[t].done_a);
      check($sformatf("tbl%0d b nwrites", t), qb_data.size(), tbl[t].wr_b);
      check($sformatf("tbl%0d b done", t), b_write_done, tbl[t].done_b);
      check($sformatf("tbl%0d b overflow", t), b_overflow, tbl[t].ovf_b);
      for (int i = 0; i < qa_data.size() && i < tbl[t].n; i++)
        check($sformatf("tbl%0d a data%0d", t, i), qa_data[i], tbl[t].w[i]);
      check_dut(0);
      check_dut(1);
      load_en = 1'b0;
      tick(1);
      check($sformatf("tbl%0d idle clear", t),
            {a_write_done, a_overflow, a_word_count, b_write_done, b_overflow, b_word_count}, 0);
    end

    // Latency: last byte edge to mem_we is 2 clocks; final sentinel write to write_done is 1 clock.
    start_session();
    send_byte(8'h13, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h01, 1, 1);
    data = 8'hfe; valid = 1'b1; ev.push_back(32'hfe);
    tick(1);
    check("lat we +1", a_mem_we, 0);
    tick(1);
    check("lat we +2", a_mem_we, 1);
    check("lat addr", a_mem_addr, 0);
    check("lat data", a_mem_wdata, 32'hfe010113);
    valid = 1'b0;
    tick(1);
    check("lat we strobe", a_mem_we, 0);
    tick(1);
    send_word(32'hffffffff, 1, 1);
    send_byte(8'hff, 1, 1); send_byte(8'hff, 1, 1); send_byte(8'hff, 1, 1);
    data = 8'hff; valid = 1'b1; ev.push_back(32'hff);
    tick(2);
    check("sent we", a_mem_we, 1);
    check("sent addr", a_mem_addr, 2);
    check("sent done early", a_write_done, 0);
    valid = 1'b0;
    tick(1);
    check("sent done +1", a_write_done, 1);
    tick(4);
    check_dut(0);
    check_dut(1);

    // Break recovery mid-word.
    start_session();
    send_byte(8'h13, 1, 1); send_byte(8'h01, 1, 1);
    send_break();
    send_word(32'h02010413, 1, 1);
    tick(6);
    check("brk data", (qa_data.size() > 0) ? qa_data[0] : 32'h0, 32'h02010413);
    check_dut(0);
    check_dut(1);

    // Break asserted together with a valid edge: the byte is dropped.
    start_session();
    send_byte(8'h11, 1, 1);
    data = 8'h22; valid = 1'b1; brk = 1'b1; ev.push_back(-1);
    tick(1);
    brk = 1'b0; valid = 1'b0;
    tick(2);
    send_word(32'hddccbbaa, 2, 1);
    tick(6);
    check("brk+valid data", (qa_data.size() > 0) ? qa_data[0] : 32'h0, 32'hddccbbaa);
    check_dut(0);

    // Held valid counts once; then reset mid-load discards everything.
    start_session();
    send_byte(8'h55, 10, 2);
    send_byte(8'h66, 1, 1); send_byte(8'h77, 1, 1); send_byte(8'h88, 1, 1);
    tick(6);
    check("held data", (qa_data.size() > 0) ? qa_data[0] : 32'h0, 32'h88776655);
    check_dut(0);
    send_byte(8'h99, 1, 1); send_byte(8'haa, 1, 1);
    resetn = 1'b0;
    tick(1);
    check_reset("midload");
    resetn = 1'b1;
    clear_logs();
    tick(2);
    send_word(32'hcafef00d, 1, 2);
    tick(6);
    check_dut(0);
    check_dut(1);

    // Long idle with a partial word.
    start_session();
    send_byte(8'haa, 1, 1); send_byte(8'hbb, 1, 1);
    tick(110);
    check("idle no write", qa_data.size(), 0);
`ifdef LOADER_TIMEOUT_EN
    check("timeout pulses", pulse_cnt, 1);
    ev.push_back(-1);
    send_word(32'h44332211, 1, 1);
`else
    check("timeout pulses", pulse_cnt, 0);
    send_byte(8'hcc, 1, 1); send_byte(8'hdd, 1, 1);
`endif
    tick(6);
    check_dut(0);
    check_dut(1);

    // Randomized programs against the word-level model.
    for (int s = 0; s < 20; s++) begin
      int nw;
      logic [31:0] w;
      start_session();
      nw = $urandom_range(1, 7);
      for (int i = 0; i < nw; i++) begin
        w = ($urandom_range(0, 2) == 0) ? 32'hffffffff : $urandom;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 11) == 0) send_break();
          send_byte(w[8*k +: 8], $urandom_range(1, 3), $urandom_range(1, 3));
        end
      end
      tick(8);
      check_dut(0);
      check_dut(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
